// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// MDU result handshake bundle (valid/ready) into the writeback arbiter.
interface rf_arb_mdu_if #(
    parameter int ADDR_W = rf_arb_pkg::ADDR_W,
    parameter int DATA_W = rf_arb_pkg::DATA_W
);

    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;

    modport master (
        output mdu_valid,
        output mdu_addr,
        output mdu_data,
        input  mdu_ready
    );

    modport slave (
        input  mdu_valid,
        input  mdu_addr,
        input  mdu_data,
        output mdu_ready
    );

endinterface

// File: rtl/rf_arb_fifo.sv
// In-order buffer of deferred MDU results with per-entry kill by address.
module rf_arb_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = rf_arb_pkg::ADDR_W,
    parameter int DATA_W = rf_arb_pkg::DATA_W,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_live,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    output logic [DEPTH-1:0]  ent_occ,
    output logic [DEPTH-1:0]  ent_live,
    output logic [ADDR_W-1:0] ent_addr [DEPTH]
);

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ent_occ  <= '0;
            ent_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && ent_occ[i] && addr_q[i] == kill_addr)
                    ent_live[i] <= 1'b0;
            end
            if (pop) begin
                ent_occ[rd_ptr]  <= 1'b0;
                ent_live[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            // A push into the slot being popped (full, no WB) must win.
            if (push) begin
                ent_occ[wr_ptr]  <= 1'b1;
                ent_live[wr_ptr] <= push_live;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_addr[i] = addr_q[i];
    end

    assign head_live = ent_occ[rd_ptr] & ent_live[rd_ptr];
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: WB stage first, buffered MDU results next.
// Optional RF_ARB_STATS_EN adds saturating stall/squash counters.
module rf_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = rf_arb_pkg::DATA_W,
    parameter int ADDR_W = rf_arb_pkg::ADDR_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    rf_arb_mdu_if.slave       mdu,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_register,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
`ifdef RF_ARB_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       squash_cnt,
`endif
    output logic [CW-1:0]     buf_count
);

    import rf_arb_pkg::*;

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic              rdy;
    logic              xfer;
    logic              pop;
    logic              fast;
    logic              push;
    logic              push_live;
    logic              wb_kill;
    logic              we;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              hit1;
    logic              hit2;

    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  ent_occ;
    logic [DEPTH-1:0]  ent_live;
    logic [ADDR_W-1:0] ent_addr [DEPTH];

    rf_arb_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_live(push_live),
        .push_addr(mdu.mdu_addr),
        .push_data(mdu.mdu_data),
        .pop      (pop),
        .kill_en  (wb_kill),
        .kill_addr(wb_addr),
        .head_live(head_live),
        .head_addr(head_addr),
        .head_data(head_data),
        .count    (count),
        .ent_occ  (ent_occ),
        .ent_live (ent_live),
        .ent_addr (ent_addr)
    );

    always_comb begin
        rdy       = (count != CW'(DEPTH)) || !wb_valid;
        xfer      = mdu.mdu_valid && rdy;
        pop       = !wb_valid && count != '0;
        fast      = !wb_valid && count == '0 && mdu.mdu_valid;
        wb_kill   = wb_valid && wb_addr != ZR;
        push      = xfer && !fast && mdu.mdu_addr != ZR;
        // WB is always younger, so an equal-address MDU result is stale.
        push_live = !(wb_kill && wb_addr == mdu.mdu_addr);
        we        = 1'b0;
        wr        = '0;
        wd        = '0;
        unique case (1'b1)
            wb_valid: begin
                we = wb_kill;
                if (we) begin
                    wr = wb_addr;
                    wd = wb_data;
                end
            end
            pop: begin
                we = head_live && head_addr != ZR;
                if (we) begin
                    wr = head_addr;
                    wd = head_data;
                end
            end
            fast: begin
                we = mdu.mdu_addr != ZR;
                if (we) begin
                    wr = mdu.mdu_addr;
                    wd = mdu.mdu_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_occ[i] && ent_live[i] && ent_addr[i] == rd_addr1)
                hit1 = 1'b1;
            if (ent_occ[i] && ent_live[i] && ent_addr[i] == rd_addr2)
                hit2 = 1'b1;
        end
        hit1 = hit1 && rd_addr1 != ZR;
        hit2 = hit2 && rd_addr2 != ZR;
    end

    // Outputs are forced to their reset values while reset is held.
    assign mdu.mdu_ready  = !reset || rdy;
    assign RegWrite       = reset && we;
    assign Write_register = reset ? wr : '0;
    assign Write_data     = reset ? wd : '0;
    assign pend_hit1      = reset && hit1;
    assign pend_hit2      = reset && hit2;
    assign buf_count      = count;

`ifdef RF_ARB_STATS_EN
    logic kill_any;

    always_comb begin
        kill_any = wb_kill && xfer && wb_addr == mdu.mdu_addr;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_kill && ent_occ[i] && ent_live[i] && ent_addr[i] == wb_addr)
                kill_any = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (mdu.mdu_valid && !rdy && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (kill_any && squash_cnt != 16'hFFFF)
                squash_cnt <= squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

    import rf_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_register;
    logic [DATA_W-1:0] Write_data;
    logic              pend_hit1;
    logic              pend_hit2;
    logic [CW-1:0]     buf_count;
`ifdef RF_ARB_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       squash_cnt;
`endif

    rf_arb_mdu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mdu ();

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mdu           (mdu),
        .RegWrite      (RegWrite),
        .Write_register(Write_register),
        .Write_data    (Write_data),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .pend_hit1     (pend_hit1),
        .pend_hit2     (pend_hit2),
`ifdef RF_ARB_STATS_EN
        .stall_cnt     (stall_cnt),
        .squash_cnt    (squash_cnt),
`endif
        .buf_count     (buf_count)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    entry_t q[$];
    int     m_stall = 0;
    int     m_squash = 0;
    bit     hold = 1'b0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic              e_rdy, xfer, fast, e_we, h1, h2, k;
        logic [ADDR_W-1:0] e_reg;
        logic [DATA_W-1:0] e_dat;
        entry_t            e;
        #1;
        e_rdy = (q.size() < DEPTH) || !wb_valid;
        xfer  = mdu.mdu_valid && e_rdy;
        fast  = 1'b0;
        e_we  = 1'b0;
        e_reg = '0;
        e_dat = '0;
        if (wb_valid) begin
            e_we = wb_addr != 0;
            if (e_we) begin e_reg = wb_addr; e_dat = wb_data; end
        end else if (q.size() > 0) begin
            e_we = q[0].live && q[0].addr != 0;
            if (e_we) begin e_reg = q[0].addr; e_dat = q[0].data; end
        end else if (mdu.mdu_valid) begin
            fast = 1'b1;
            e_we = mdu.mdu_addr != 0;
            if (e_we) begin e_reg = mdu.mdu_addr; e_dat = mdu.mdu_data; end
        end
        h1 = 1'b0;
        h2 = 1'b0;
        foreach (q[i]) begin
            if (q[i].live && q[i].addr == rd_addr1 && rd_addr1 != 0) h1 = 1'b1;
            if (q[i].live && q[i].addr == rd_addr2 && rd_addr2 != 0) h2 = 1'b1;
        end
        chk("RegWrite", RegWrite, e_we);
        chk("Write_register", Write_register, e_reg);
        chk("Write_data", Write_data, e_dat);
        chk("mdu_ready", mdu.mdu_ready, e_rdy);
        chk("pend_hit1", pend_hit1, h1);
        chk("pend_hit2", pend_hit2, h2);
        chk("buf_count", buf_count, q.size());
        hold = mdu.mdu_valid && !e_rdy;
        @(posedge clk);
        if (mdu.mdu_valid && !e_rdy) m_stall++;
        if (wb_valid && wb_addr != 0) begin
            k = xfer && mdu.mdu_addr == wb_addr;
            foreach (q[i]) begin
                if (q[i].live && q[i].addr == wb_addr) begin
                    q[i].live = 1'b0;
                    k = 1'b1;
                end
            end
            if (k) m_squash++;
        end
        if (!wb_valid && q.size() > 0) void'(q.pop_front());
        if (xfer && !fast && mdu.mdu_addr != 0) begin
            e.live = !(wb_valid && wb_addr != 0 && wb_addr == mdu.mdu_addr);
            e.addr = mdu.mdu_addr;
            e.data = mdu.mdu_data;
            q.push_back(e);
        end
        #1;
`ifdef RF_ARB_STATS_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("squash_cnt", squash_cnt, m_squash);
`endif
    endtask

    task automatic drv(input logic wv, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic mv,
                       input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        wb_valid      = wv;
        wb_addr       = wa;
        wb_data       = wd;
        mdu.mdu_valid = mv;
        mdu.mdu_addr  = ma;
        mdu.mdu_data  = md;
        rd_addr1      = r1;
        rd_addr2      = r2;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        wb_valid      = 1'b0;
        wb_addr       = '0;
        wb_data       = '0;
        mdu.mdu_valid = 1'b0;
        mdu.mdu_addr  = '0;
        mdu.mdu_data  = '0;
        rd_addr1      = '0;
        rd_addr2      = '0;
        #2;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_mdu_ready", mdu.mdu_ready, 1);
        chk("rst_buf_count", buf_count, 0);
        chk("rst_pend", {pend_hit1, pend_hit2}, 0);
        @(negedge clk);
        reset = 1'b1;

        // idle start: fast path
        drv(0, 0, 0, 1, 3, 'h11, 3, 0);
        // conflict: WB wins, MDU buffered then drained
        drv(1, 5, 'hAA, 1, 6, 'hBB, 6, 0);
        drv(0, 0, 0, 0, 0, 0, 6, 0);
        chk("conflict_drained", buf_count, 0);
        // back-pressure: MDU holds fields while not ready
        for (int i = 0; i < 4; i++)
            drv(1, 9, DATA_W'(i), 1, ADDR_W'(i < 2 ? 10 + i : 12), 'h100 + 32'(i), 10, 11);
        chk("bp_count", buf_count, 2);
`ifdef RF_ARB_STATS_EN
        chk("bp_stall", stall_cnt, 2);
`endif
        drv(0, 0, 0, 1, 12, 'h102, 12, 11);
        drv(0, 0, 0, 0, 0, 0, 12, 11);
        drv(0, 0, 0, 0, 0, 0, 12, 0);
        // WAW squash of buffered r7
        drv(1, 5, 'h3, 1, 7, 'h1, 7, 0);
        drv(1, 7, 'h2, 0, 0, 0, 7, 0);
        drv(0, 0, 0, 0, 0, 0, 7, 0);
        // register 0 from both sources
        drv(0, 0, 0, 1, 0, 'h55, 0, 0);
        drv(1, 0, 'h66, 0, 0, 0, 0, 0);
        drv(1, 4, 'h1, 1, 0, 'h77, 0, 0);
        chk("zero_count", buf_count, 0);
        // reset mid-operation between clock edges
        drv(1, 1, 1, 1, 2, 2, 2, 4);
        drv(1, 3, 3, 1, 4, 4, 2, 4);
        wb_valid      = 1'b0;
        mdu.mdu_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("amid_buf_count", buf_count, 0);
        chk("amid_RegWrite", RegWrite, 0);
        chk("amid_mdu_ready", mdu.mdu_ready, 1);
        chk("amid_pend", {pend_hit1, pend_hit2}, 0);
        q.delete();
        m_stall  = 0;
        m_squash = 0;
        hold     = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // randomized traffic with a well-behaved MDU
        for (int n = 0; n < 400; n++) begin
            wb_valid = ($urandom_range(0, 99) < 55);
            wb_addr  = ADDR_W'($urandom_range(0, 7));
            wb_data  = $urandom;
            if (!hold) begin
                mdu.mdu_valid = ($urandom_range(0, 99) < 60);
                mdu.mdu_addr  = ADDR_W'($urandom_range(0, 7));
                mdu.mdu_data  = $urandom;
            end
            rd_addr1 = ADDR_W'($urandom_range(0, 7));
            rd_addr2 = ADDR_W'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/Write_register/Write_data) between two writeback sources:
  - the in-order pipeline WB stage, which has fixed highest priority and no back-pressure;
  - the multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake.
- MDU results that lose arbitration wait in a small in-order buffer.
- Pending buffered destinations are reported to hazard detection so decode can stall.
- Sits between the WB/MDU outputs and the register-file write port.

Parameters:
- DEPTH, 2, MDU buffer entries; power of two, >= 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_addr  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  arbiter accepts MDU result this cycle.
- mdu_addr  in  ADDR_W  MDU destination register.
- mdu_data  in  DATA_W  MDU result.
- RegWrite  out  1  register-file write enable.
- Write_register  out  ADDR_W  register-file write index.
- Write_data  out  DATA_W  register-file write data.
- rd_addr1  in  ADDR_W  decode source register 1.
- rd_addr2  in  ADDR_W  decode source register 2.
- pend_hit1  out  1  rd_addr1 matches a live buffered MDU entry.
- pend_hit2  out  1  rd_addr2 matches a live buffered MDU entry.
- buf_count  out  clog2(DEPTH)+1  number of occupied buffer entries.

Behaviour:
- Reset (reset==0, asynchronous):
  - buffer emptied; read/write pointers, count and all live bits cleared;
  - all outputs 0 except mdu_ready=1.
  - Results mid-flight are lost; the MDU is reset by the same signal.
- Write-port selection is combinational, one write per cycle, in priority order:
  1. wb_valid=1: drive the wb fields. RegWrite = (wb_addr != 0).
  2. Else, buffer non-empty: pop the head. RegWrite = head.live && (head.addr != 0).
  3. Else, mdu_valid=1: fast path, write MDU directly with no enqueue. RegWrite = (mdu_addr != 0).
  4. Else RegWrite=0.
  - Write_register and Write_data are don't-care when RegWrite=0; drive 0.
- MDU handshake:
  - mdu_ready = (buf_count < DEPTH) || !wb_valid.
  - mdu_ready depends only on registered count and wb_valid, never on mdu_valid.
  - Transfer occurs when mdu_valid && mdu_ready. A transfer not taken by the fast path is enqueued at the tail at posedge.
  - Full buffer with wb_valid=0: the head pops and the new entry enqueues in the same cycle; count is unchanged.
  - mdu_valid held with mdu_ready=0: the MDU keeps its fields stable; the arbiter does not sample them.
- Ordering (WAW), based on pipeline WB always being younger than any MDU result:
  - When wb_valid && wb_addr != 0, every buffered entry with the same addr is cleared to live=0 at posedge. A dead entry still pops but does not write.
  - An MDU result transferring in the same cycle as wb_valid with equal non-zero addr is enqueued dead.
- Register 0:
  - never written;
  - an MDU transfer with addr 0 completes its handshake and is discarded; it is not enqueued.
- Hazard flags (combinational):
  - pend_hitN = OR over occupied entries of (live && addr == rd_addrN && rd_addrN != 0).
  - The fast path never sets pend_hit; the value is already at the register file and its bypass covers it.
- Latency:
  - WB: 0 cycles.
  - MDU: 0 cycles via the fast path; otherwise 1 + (entries ahead) cycles without WB activity.
- Pointers wrap modulo DEPTH; count saturates neither up nor down because the handshake prevents overflow.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and squash_cnt[15:0], saturating at 16'hFFFF, cleared by reset.
  - stall_cnt increments each cycle with mdu_valid && !mdu_ready.
  - squash_cnt increments by 1 per cycle in which any live entry, or the incoming MDU result, is killed.
- Not defined: no counters and no extra ports; all other behaviour identical.

Decomposition:
- Shared package (rf_arb_pkg):
  - DATA_W and ADDR_W defaults;
  - typedef of the buffer entry {live, addr, data};
  - ZERO_REG constant.
- One sub-module: rf_arb_fifo, DEPTH entries, with push/pop, per-entry kill by address match, and per-entry addr/live exposure for the hazard compare.
- Selection, handshake and hazard logic stay in the top module.

Test Plan:
- Idle start: reset, then mdu_valid with addr=3, data=0x11 and wb_valid=0 -> same cycle RegWrite=1, Write_register=3, Write_data=0x11; buf_count stays 0.
- Conflict: wb_valid (addr 5, 0xAA) and mdu (addr 6, 0xBB) together -> cycle 0 writes r5=0xAA, mdu enqueued, pend_hit1=1 for rd_addr1=6; cycle 1 writes r6=0xBB, buf_count back to 0.
- Back-pressure: wb_valid held for 4 cycles with mdu_valid every cycle -> mdu_ready=1 for 2 cycles then 0, buf_count=2, stall_cnt=2 when RF_ARB_STATS_EN is defined.
- WAW squash: buffer holds r7=0x1; wb writes r7=0x2 -> entry killed, pend_hit drops, later pop gives RegWrite=0, final r7=0x2.
- Zero register: mdu addr 0 and wb addr 0 in separate cycles -> RegWrite=0 both times, handshake completes, buf_count=0.
- Reset mid-operation: buffer with 2 entries, drive reset=0 between clock edges -> buf_count=0, RegWrite=0 and mdu_ready=1 immediately, with no posedge needed.
